// File: rtl/weight_buffer_unit.sv
// weight_buffer_unit
//   Filter-weight staging buffer between the memory read port and the PE rows.
//   A load fetches a mode-dependent number of 64-bit words (MODE1 = DEPTH,
//   MODE2 = DEPTH/2, MODE3 = DEPTH/4) into local storage. The filter is then
//   streamed to the PE rows as one pass per output_filter request, and is held
//   for further passes until free_weight_buffer releases it.
//
//   Every output port is the internally computed value registered once more,
//   so each *_delay port lags its internal signal by exactly one clock.
//
// Ports
//   clk                   rising-edge clock
//   rst_n                 asynchronous active-low reset
//   mode_in               operating mode, sampled when a load starts
//   start_load            begin a filter fetch (honoured only in IDLE)
//   mem_data_valid        weight_data holds a valid word this cycle
//   weight_data           64-bit weight word from memory
//   free_weight_buffer    release the held filter (highest priority)
//   output_filter         request an output pass
//   packet_out_delay      per-row packets {valid, data}
//   mem_req_delay         memory word request
//   finish_output_delay   one-cycle pulse with the last packet of a pass
//   ready_to_output_delay filter loaded and not streaming
//
// Build option
//   WB_BCAST_EN  when defined, each streamed word is broadcast to every row
//                with valid=1 instead of being routed to row (idx mod NUM_ROWS).

package weight_buffer_unit_pkg;
  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2
  } op_mode_t;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] data;
  } pe_in_packet_t;
endpackage

module weight_buffer_unit
  import weight_buffer_unit_pkg::*;
#(
  parameter int DATA_W   = WORD_W,
  parameter int DEPTH    = 88,
  parameter int NUM_ROWS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  op_mode_t            mode_in,
  input  logic                start_load,
  input  logic                mem_data_valid,
  input  logic [DATA_W-1:0]   weight_data,
  input  logic                free_weight_buffer,
  input  logic                output_filter,
  output pe_in_packet_t       packet_out_delay [0:NUM_ROWS-1],
  output logic                mem_req_delay,
  output logic                finish_output_delay,
  output logic                ready_to_output_delay
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FULL   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] need_words(input op_mode_t m);
    logic [CNT_W-1:0] n;
    case (m)
      MODE2:   n = CNT_W'(DEPTH / 2);
      MODE3:   n = CNT_W'(DEPTH / 4);
      default: n = CNT_W'(DEPTH);
    endcase
    return n;
  endfunction

  // Weight storage: not reset, contents are only meaningful after a load.
  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_nx;
  op_mode_t          mode_q, mode_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [CNT_W-1:0]  idx, idx_nx;
  logic [ROW_W-1:0]  row, row_nx;
  logic [CNT_W-1:0]  need;

  logic              mem_req_p0;
  logic              ready_p0;
  logic              finish_p0;
  logic              wr_en_p0;
  logic              vld_p0;
  logic [DATA_W-1:0] rd_data_p0;
  pe_in_packet_t     pkt_p0 [0:NUM_ROWS-1];

  assign need       = need_words(mode_q);
  assign rd_data_p0 = mem[idx[ADDR_W-1:0]];

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_q <= MODE1;
      cnt    <= '0;
      idx    <= '0;
      row    <= '0;
    end else begin
      state  <= state_nx;
      mode_q <= mode_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      row    <= row_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_p0) begin
      mem[cnt[ADDR_W-1:0]] <= weight_data;
    end
  end

  // Stage p0: next-state and internal (undelayed) outputs
  always_comb begin
    state_nx   = state;
    mode_nx    = mode_q;
    cnt_nx     = cnt;
    idx_nx     = idx;
    row_nx     = row;
    mem_req_p0 = 1'b0;
    ready_p0   = 1'b0;
    finish_p0  = 1'b0;
    wr_en_p0   = 1'b0;
    vld_p0     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_load) begin
          mode_nx  = mode_in;
          cnt_nx   = '0;
          state_nx = ST_LOAD;
        end
      end

      ST_LOAD: begin
        mem_req_p0 = (cnt < need);
        if (free_weight_buffer) begin
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end else if (mem_data_valid && (cnt < need)) begin
          wr_en_p0 = 1'b1;
          cnt_nx   = cnt + CNT_W'(1);
          if (cnt + CNT_W'(1) == need) begin
            state_nx = ST_FULL;
          end
        end
      end

      ST_FULL: begin
        ready_p0 = 1'b1;
        if (free_weight_buffer) begin
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end else if (output_filter) begin
          idx_nx   = '0;
          row_nx   = '0;
          state_nx = ST_OUTPUT;
        end
      end

      ST_OUTPUT: begin
        if (free_weight_buffer) begin
          // Abort: the current word is dropped and no finish pulse is raised.
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end else begin
          vld_p0 = 1'b1;
          idx_nx = idx + CNT_W'(1);
          row_nx = (row == ROW_W'(NUM_ROWS - 1)) ? '0 : row + ROW_W'(1);
          if (idx == need - CNT_W'(1)) begin
            finish_p0 = 1'b1;
            state_nx  = ST_FULL;
          end
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  // Row routing of the streamed word
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      pkt_p0[r] = '0;
    end
    if (vld_p0) begin
`ifdef WB_BCAST_EN
      for (int r = 0; r < NUM_ROWS; r++) begin
        pkt_p0[r].valid = 1'b1;
        pkt_p0[r].data  = rd_data_p0;
      end
`else
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (row == ROW_W'(r)) begin
          pkt_p0[r].valid = 1'b1;
          pkt_p0[r].data  = rd_data_p0;
        end
      end
`endif
    end
  end

  // Stage p1: output delay register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_delay         <= 1'b0;
      finish_output_delay   <= 1'b0;
      ready_to_output_delay <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        packet_out_delay[r] <= '0;
      end
    end else begin
      mem_req_delay         <= mem_req_p0;
      finish_output_delay   <= finish_p0;
      ready_to_output_delay <= ready_p0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        packet_out_delay[r] <= pkt_p0[r];
      end
    end
  end

endmodule

// File: tb/tb_weight_buffer_unit.sv
module tb_weight_buffer_unit;
  import weight_buffer_unit_pkg::*;

  typedef struct {
    int          row;
    logic [63:0] data;
    logic        fin;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  op_mode_t      mode_in = MODE1;
  logic          start_load = 1'b0;
  logic          mem_data_valid = 1'b0;
  logic [63:0]   weight_data = '0;
  logic          free_weight_buffer = 1'b0;
  logic          output_filter = 1'b0;
  pe_in_packet_t pkt [0:5];
  logic          mem_req_d;
  logic          fin_d;
  logic          rdy_d;

  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];

  weight_buffer_unit dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .mode_in               (mode_in),
    .start_load            (start_load),
    .mem_data_valid        (mem_data_valid),
    .weight_data           (weight_data),
    .free_weight_buffer    (free_weight_buffer),
    .output_filter         (output_filter),
    .packet_out_delay      (pkt),
    .mem_req_delay         (mem_req_d),
    .finish_output_delay   (fin_d),
    .ready_to_output_delay (rdy_d)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  function automatic logic [63:0] outputs_or();
    logic [63:0] acc;
    acc = {61'd0, mem_req_d, fin_d, rdy_d};
    for (int r = 0; r < 6; r++) begin
      acc = acc | pkt[r].data | {63'd0, pkt[r].valid};
    end
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation whenever the DUT presents a packet or finish.
  always @(negedge clk) begin
    int          nv;
    int          vrow;
    logic [63:0] vdata;
    logic [63:0] stray;
    exp_t        e;
    if (rst_n) begin
      nv = 0; vrow = -1; vdata = '0; stray = '0;
      for (int r = 0; r < 6; r++) begin
        if (pkt[r].valid) begin
          nv++;
          vrow  = r;
          vdata = pkt[r].data;
        end else begin
          stray = stray | pkt[r].data;
        end
      end
      if (nv != 0 || fin_d) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: valid_rows=%0d finish=%0b expected nothing", nv, fin_d);
        end else begin
          e = sbq.pop_front();
          chk("pkt_nvalid", 64'(nv), 64'd1);
          chk("pkt_row", 64'(vrow), 64'(e.row));
          chk("pkt_data", vdata, e.data);
          chk("pkt_finish", {63'd0, fin_d}, {63'd0, e.fin});
          chk("pkt_stray_data", stray, 64'd0);
        end
      end
    end
  end

  task automatic drain(input string name, input int max);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk({name, "_drain_left"}, 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  // Load n words whose bytes are all (base+i), then two ignored extra words.
  task automatic load(input string name, input op_mode_t m, input int n, input logic [7:0] base);
    mode_in    = m;
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    chk({name, "_memreq_lat1"}, {63'd0, mem_req_d}, 64'd0);
    tick();
    chk({name, "_memreq_lat2"}, {63'd0, mem_req_d}, 64'd1);
    for (int i = 0; i < n; i++) begin
      mem_data_valid = 1'b1;
      weight_data    = rep(base + 8'(i));
      chk({name, "_memreq_hold"}, {63'd0, mem_req_d}, 64'd1);
      tick();
    end
    chk({name, "_ready_not_early"}, {63'd0, rdy_d}, 64'd0);
    weight_data = rep(8'hEE);
    tick();
    chk({name, "_ready_after_load"}, {63'd0, rdy_d}, 64'd1);
    chk({name, "_memreq_dropped"}, {63'd0, mem_req_d}, 64'd0);
    tick();
    mem_data_valid = 1'b0;
    weight_data    = '0;
  endtask

  task automatic run_pass(input string name, input int n, input logic [7:0] base);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.row  = k % 6;
      e.data = rep(base + 8'(k));
      e.fin  = (k == n - 1);
      sbq.push_back(e);
    end
    output_filter = 1'b1;
    tick();
    output_filter = 1'b0;
    chk({name, "_no_pkt_lat1"}, {63'd0, pkt[0].valid}, 64'd0);
    tick();
    chk({name, "_first_pkt_lat2"}, {63'd0, pkt[0].valid}, 64'd1);
    chk({name, "_ready_low"}, {63'd0, rdy_d}, 64'd0);
    drain(name, n + 20);
    chk({name, "_ready_back"}, {63'd0, rdy_d}, 64'd1);
    chk({name, "_finish_once"}, {63'd0, fin_d}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_outputs_during", outputs_or(), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("reset_outputs_after", outputs_or(), 64'd0);

    // MODE1 load and pass
    load("m1_load", MODE1, 88, 8'h01);
    run_pass("m1_pass", 88, 8'h01);

    // Free, then MODE3 load and pass
    free_weight_buffer = 1'b1;
    tick();
    free_weight_buffer = 1'b0;
    tick();
    chk("free_ready_drop", {63'd0, rdy_d}, 64'd0);
    load("m3_load", MODE3, 22, 8'hA0);
    run_pass("m3_pass", 22, 8'hA0);

    // free and output_filter together in FULL: nothing streams
    free_weight_buffer = 1'b1;
    output_filter      = 1'b1;
    tick();
    free_weight_buffer = 1'b0;
    output_filter      = 1'b0;
    tick();
    chk("freeprio_ready_drop", {63'd0, rdy_d}, 64'd0);
    repeat (4) tick();
    chk("freeprio_no_pkt", outputs_or(), 64'd0);

    // Async reset in the middle of a MODE2 pass
    load("m2_load", MODE2, 44, 8'h30);
    for (int k = 0; k < 5; k++) begin
      e.row  = k % 6;
      e.data = rep(8'h30 + 8'(k));
      e.fin  = 1'b0;
      sbq.push_back(e);
    end
    output_filter = 1'b1;
    tick();
    output_filter = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midout_reset_clear", outputs_or(), 64'd0);
    chk("midout_pkts_seen", 64'(sbq.size()), 64'd0);
    sbq.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    repeat (3) tick();
    chk("midout_quiet_after", outputs_or(), 64'd0);

    // Clean reload after reset
    load("reload", MODE3, 22, 8'hC0);
    run_pass("reload_pass", 22, 8'hC0);

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
